// File: rtl/fifo_uart_tx.sv
// FIFO-fed 8N1 UART transmitter: pops one byte per frame from the byte FIFO
// and shifts it out LSB first between a start bit and a stop bit.
module fifo_uart_tx #(
  parameter int ClocksPerBit = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] fByte,
  input  logic       fEmpty,
  output logic       fPop,
  input  logic       enable,
  output logic       tx,
  output logic       busy
);

  localparam int CountWidth = $clog2(ClocksPerBit);
  localparam logic [CountWidth-1:0] LastCount = CountWidth'(ClocksPerBit - 1);
  localparam logic [CountWidth-1:0] CountOne  = CountWidth'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    START,
    DATA,
    STOP
  } stateType;

  stateType              stateReg, stateNext;
  logic [CountWidth-1:0] countReg, countNext;
  logic [2:0]            indexReg, indexNext;
  logic [7:0]            shiftReg, shiftNext;
  logic                  popNext;
  logic                  txNext;
  logic                  busyNext;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stateReg <= IDLE;
      countReg <= '0;
      indexReg <= '0;
      shiftReg <= '0;
      fPop     <= 1'b0;
      tx       <= 1'b1;
      busy     <= 1'b0;
    end else begin
      stateReg <= stateNext;
      countReg <= countNext;
      indexReg <= indexNext;
      shiftReg <= shiftNext;
      fPop     <= popNext;
      tx       <= txNext;
      busy     <= busyNext;
    end
  end

  always_comb begin
    stateNext = stateReg;
    countNext = countReg;
    indexNext = indexReg;
    shiftNext = shiftReg;

    case (stateReg)
      IDLE: begin
        countNext = '0;
        indexNext = '0;
        if (enable && !fEmpty) begin
          stateNext = FETCH;
        end
      end

      FETCH: begin
        countNext = '0;
        stateNext = START;
      end

      START: begin
        // The pop strobe is a flop, so the FIFO answers it one cycle later:
        // the byte is on fByte during the first start-bit cycle.
        if (countReg == '0) begin
          shiftNext = fByte;
        end
        if (countReg == LastCount) begin
          countNext = '0;
          indexNext = '0;
          stateNext = DATA;
        end else begin
          countNext = countReg + CountOne;
        end
      end

      DATA: begin
        if (countReg == LastCount) begin
          countNext = '0;
          shiftNext = {1'b0, shiftReg[7:1]};
          if (indexReg == 3'd7) begin
            stateNext = STOP;
          end else begin
            indexNext = indexReg + 3'd1;
          end
        end else begin
          countNext = countReg + CountOne;
        end
      end

      STOP: begin
        if (countReg == LastCount) begin
          countNext = '0;
          stateNext = IDLE;
        end else begin
          countNext = countReg + CountOne;
        end
      end

      default: begin
        stateNext = IDLE;
        countNext = '0;
        indexNext = '0;
      end
    endcase

    // Outputs are registered from the next state so they line up with it.
    popNext  = (stateReg == IDLE) && (stateNext == FETCH);
    busyNext = (stateNext != IDLE);
    txNext   = 1'b1;
    if (stateNext == START) begin
      txNext = 1'b0;
    end else if (stateNext == DATA) begin
      txNext = shiftNext[0];
    end
  end

endmodule
